// File: rtl/lvds_tx_pkg.sv
// Shared constants, slot-length helper and load-source encoding for the LVDS transmit serializer.
package lvds_tx_pkg;

    localparam logic [7:0] DEF_IDLE_WORD  = 8'hC5;
    localparam logic [7:0] DEF_TRAIN_WORD = 8'h6A;

    typedef enum logic [1:0] {
        SRC_IDLE  = 2'd0,
        SRC_DATA  = 2'd1,
        SRC_TRAIN = 2'd2
    } load_src_e;

    function automatic int S(input int data_w, input int lanes);
        return data_w / lanes;
    endfunction

endpackage

// File: rtl/lvds_lane_shifter.sv
// One serial lane: S-bit parallel-load shift register, MSB leaves first.
module lvds_lane_shifter #(
    parameter int               S_LEN   = 4,
    parameter logic [S_LEN-1:0] RST_VAL = {S_LEN{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [S_LEN-1:0] load_val,
    output logic             ser_bit
);

    logic [S_LEN-1:0] shift_r;

    // Load a new lane slice at the slot boundary, otherwise shift left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= RST_VAL;
        end else if (load) begin
            shift_r <= load_val;
        end else begin
            shift_r <= {shift_r[S_LEN-2:0], 1'b0};
        end
    end

    assign ser_bit = shift_r[S_LEN-1];

endmodule

// File: rtl/lvds_serializer_tx.sv
// Soft LVDS transmit serializer: double-buffered word intake, LANES-wide MSB-first shift-out, framing clock.
// Optional link training is built when LVDS_TX_TRAIN_EN is defined.
module lvds_serializer_tx
    import lvds_tx_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                LANES      = 2,
    parameter logic [DATA_W-1:0] IDLE_WORD  = DATA_W'(DEF_IDLE_WORD),
    parameter logic [DATA_W-1:0] TRAIN_WORD = DATA_W'(DEF_TRAIN_WORD),
    parameter int                TRAIN_LEN  = 16
) (
    input  logic              input_clk,
    input  logic              arst,
    input  logic [DATA_W-1:0] input_data,
    input  logic              in_valid,
`ifdef LVDS_TX_TRAIN_EN
    input  logic              train_req,
    output logic              train_busy,
`endif
    output logic              in_ready,
    output logic [LANES-1:0]  output_data,
    output logic              data_clk
);

    localparam int            SL       = S(DATA_W, LANES);
    localparam int            CW       = (SL > 1) ? $clog2(SL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SL - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(SL / 2);

    generate
        if (((DATA_W % LANES) != 0) || ((SL % 2) != 0) || (SL < 2)) begin : g_bad_slot
            $error("lvds_serializer_tx: DATA_W/LANES must give an even slot length of at least 2");
        end
        if ((TRAIN_LEN < 1) || (TRAIN_LEN > 65535)) begin : g_bad_train_len
            $error("lvds_serializer_tx: TRAIN_LEN must be within 1..65535");
        end
    endgenerate

    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     cnt_next_s;
    logic              boundary_s;
    logic              accept_s;
    logic              data_clk_r;
    logic [DATA_W-1:0] hold_r;
    logic              hold_full_r;
    logic              train_active_s;
    load_src_e         src_s;
    logic [DATA_W-1:0] load_word_s;

    assign boundary_s = (cnt_r == CNT_LAST);
    assign accept_s   = in_valid && !hold_full_r;
    assign in_ready   = !hold_full_r;
    assign data_clk   = data_clk_r;

    // Next bit position within the slot.
    always_comb begin
        if (boundary_s) begin
            cnt_next_s = {CW{1'b0}};
        end else begin
            cnt_next_s = cnt_r + CW'(1);
        end
    end

    // Bit counter and framing clock; data_clk follows the counter it will sit beside.
    always_ff @(posedge input_clk or negedge arst) begin
        if (!arst) begin
            cnt_r      <= {CW{1'b0}};
            data_clk_r <= 1'b1;
        end else begin
            cnt_r      <= cnt_next_s;
            data_clk_r <= (cnt_next_s < CNT_HALF);
        end
    end

`ifdef LVDS_TX_TRAIN_EN
    logic        train_busy_r;
    logic [15:0] train_left_r;

    assign train_active_s = train_busy_r && (train_left_r != 16'd0);
    assign train_busy     = train_busy_r;

    // Training request latch and remaining-slot counter; busy drops when the first normal word loads.
    always_ff @(posedge input_clk or negedge arst) begin
        if (!arst) begin
            train_busy_r <= 1'b0;
            train_left_r <= 16'd0;
        end else if (!train_busy_r) begin
            if (train_req) begin
                train_busy_r <= 1'b1;
                train_left_r <= 16'(TRAIN_LEN);
            end
        end else if (boundary_s) begin
            if (train_left_r != 16'd0) begin
                train_left_r <= train_left_r - 16'd1;
            end else begin
                train_busy_r <= 1'b0;
            end
        end
    end
`else
    assign train_active_s = 1'b0;
`endif

    // Source priority for the next slot: training, then held data, then idle.
    always_comb begin
        if (train_active_s) begin
            src_s = SRC_TRAIN;
        end else if (hold_full_r) begin
            src_s = SRC_DATA;
        end else begin
            src_s = SRC_IDLE;
        end
    end

    // Word presented to the lane shifters at the slot boundary.
    always_comb begin
        case (src_s)
            SRC_TRAIN: load_word_s = TRAIN_WORD;
            SRC_DATA:  load_word_s = hold_r;
            SRC_IDLE:  load_word_s = IDLE_WORD;
            default:   load_word_s = IDLE_WORD;
        endcase
    end

    // Holding register: filled by an accept, drained only when its word is loaded.
    always_ff @(posedge input_clk or negedge arst) begin
        if (!arst) begin
            hold_r      <= {DATA_W{1'b0}};
            hold_full_r <= 1'b0;
        end else if (accept_s) begin
            hold_r      <= input_data;
            hold_full_r <= 1'b1;
        end else if (boundary_s && (src_s == SRC_DATA)) begin
            hold_full_r <= 1'b0;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        lvds_lane_shifter #(
            .S_LEN   (SL),
            .RST_VAL (IDLE_WORD[l*SL +: SL])
        ) u_shifter (
            .clk      (input_clk),
            .rst_n    (arst),
            .load     (boundary_s),
            .load_val (load_word_s[l*SL +: SL]),
            .ser_bit  (output_data[l])
        );
    end

endmodule

// File: tb/tb_lvds_serializer_tx.sv
// Self-checking bench for lvds_serializer_tx: slot-level reference model plus literal pins.
module tb_lvds_serializer_tx;

    localparam int         DW    = 8;
    localparam int         LN    = 2;
    localparam int         S     = DW / LN;
    localparam int         TLEN  = 3;
    localparam logic [7:0] IDLE  = 8'hC5;
    localparam logic [7:0] TRAIN = 8'h6A;
`ifdef LVDS_TX_TRAIN_EN
    localparam bit TRAIN_ON = 1'b1;
`else
    localparam bit TRAIN_ON = 1'b0;
`endif

    logic          input_clk = 1'b0;
    logic          arst = 1'b1;
    logic [DW-1:0] input_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [LN-1:0] output_data;
    logic          data_clk;
    logic          train_req = 1'b0;
    logic          train_busy;

    logic [15:0]   d16 = '0;
    logic          v16 = 1'b0;
    logic          rdy16, dclk16, busy16;
    logic [3:0]    out16;

    always #5 input_clk = ~input_clk;

    lvds_serializer_tx #(.DATA_W(DW), .LANES(LN), .TRAIN_LEN(TLEN)) u_dut (
        .input_clk   (input_clk),
        .arst        (arst),
        .input_data  (input_data),
        .in_valid    (in_valid),
`ifdef LVDS_TX_TRAIN_EN
        .train_req   (train_req),
        .train_busy  (train_busy),
`endif
        .in_ready    (in_ready),
        .output_data (output_data),
        .data_clk    (data_clk)
    );

    lvds_serializer_tx #(.DATA_W(16), .LANES(4)) u_dut16 (
        .input_clk   (input_clk),
        .arst        (arst),
        .input_data  (d16),
        .in_valid    (v16),
`ifdef LVDS_TX_TRAIN_EN
        .train_req   (1'b0),
        .train_busy  (busy16),
`endif
        .in_ready    (rdy16),
        .output_data (out16),
        .data_clk    (dclk16)
    );

`ifndef LVDS_TX_TRAIN_EN
    assign train_busy = 1'b0;
    assign busy16     = 1'b0;
`endif

    // Reference model: position in slot, word on the wire, holding queue, training state.
    int            m_pos;
    logic [DW-1:0] m_cur;
    logic [DW-1:0] m_hq[$];
    bit            m_busy;
    int            m_left;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [1:0] idle_pat [4] = '{2'b10, 2'b11, 2'b00, 2'b01};
    logic [1:0] a3_pat   [4] = '{2'b10, 2'b00, 2'b11, 2'b01};
    logic [3:0] w16_pat  [4] = '{4'h0, 4'h1, 4'h6, 4'hA};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m_cur  = IDLE;
        m_hq.delete();
        m_busy = 1'b0;
        m_left = 0;
    endtask

    task automatic model_step(input logic v, input logic [DW-1:0] d, input logic tr);
        bit pre_empty;
        bit pre_busy;
        pre_empty = (m_hq.size() == 0);
        pre_busy  = m_busy;
        if (m_pos == S - 1) begin
            if (m_busy && m_left > 0) begin
                m_cur = TRAIN;
                m_left--;
            end else begin
                m_busy = 1'b0;
                if (m_hq.size() > 0) m_cur = m_hq.pop_front();
                else                 m_cur = IDLE;
            end
        end
        if (v && pre_empty) m_hq.push_back(d);
        if (TRAIN_ON && tr && !pre_busy) begin
            m_busy = 1'b1;
            m_left = TLEN;
        end
        m_pos = (m_pos + 1) % S;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick(input logic v, input logic [DW-1:0] d, input logic tr);
        in_valid   = v;
        input_data = d;
        train_req  = tr;
        @(posedge input_clk);
        if (arst) model_step(v, d, tr);
        @(negedge input_clk);
    endtask

    task automatic do_reset();
        #2 arst = 1'b0;
        model_reset();
        chk_en = 1'b1;
        #1;
        chk("rst_lanes", output_data, 2'b10);
        chk("rst_data_clk", data_clk, 1'b1);
        chk("rst_in_ready", in_ready, 1'b1);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        #1 arst = 1'b1;
    endtask

    task automatic align();
        for (int c = 0; c < 400; c++) begin
            if (m_pos == 0 && m_hq.size() == 0 && !m_busy) break;
            tick(1'b0, '0, 1'b0);
        end
        chk("align_pos", m_pos, 0);
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge input_clk) begin : cmp_proc
        logic [LN-1:0] eo;
        if (chk_en) begin
            for (int l = 0; l < LN; l++) eo[l] = m_cur[l*S + (S - 1 - m_pos)];
            chk("lanes", output_data, eo);
            chk("data_clk", data_clk, (m_pos < S/2));
            chk("in_ready", in_ready, (m_hq.size() == 0));
`ifdef LVDS_TX_TRAIN_EN
            chk("train_busy", train_busy, m_busy);
`endif
        end
    end

    initial begin
        int idx;
        bit e;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            chk("idle_lit", output_data, idle_pat[i % 4]);
            tick(1'b0, '0, 1'b0);
        end

        tick(1'b1, 8'hA3, 1'b0);
        chk("ready_low_lit", in_ready, 1'b0);
        repeat (3) tick(1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("a3_lit", output_data, a3_pat[i]);
            tick(1'b0, '0, 1'b0);
        end

        v16 = 1'b1;
        d16 = 16'h1234;
        tick(1'b0, '0, 1'b0);
        v16 = 1'b0;
        repeat (3) tick(1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("w16_lanes", out16, w16_pat[i]);
            chk("w16_data_clk", dclk16, (i < 2));
            tick(1'b0, '0, 1'b0);
        end

        idx = 0;
        for (int c = 0; c < 3000 && idx < 256; c++) begin
            e = (m_hq.size() == 0);
            tick(1'b1, 8'(idx), 1'b0);
            if (e) idx++;
        end
        chk("stream_count", idx, 256);
        repeat (12) tick(1'b0, '0, 1'b0);

        for (int i = 0; i < 800; i++) begin
            tick(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 63) == 0));
        end

`ifdef LVDS_TX_TRAIN_EN
        align();
        tick(1'b1, 8'h5A, 1'b0);
        tick(1'b0, '0, 1'b1);
        chk("train_busy_set", train_busy, 1'b1);
        repeat (4) tick(1'b0, '0, 1'b0);
        chk("train1_lit", output_data, 2'b11);
        repeat (8) tick(1'b0, '0, 1'b0);
        chk("train3_lit", output_data, 2'b11);
        chk("train3_busy", train_busy, 1'b1);
        repeat (4) tick(1'b0, '0, 1'b0);
        chk("post_train_lit", output_data, 2'b01);
        chk("post_train_busy", train_busy, 1'b0);
`endif

        align();
        tick(1'b1, 8'h3C, 1'b0);
        tick(1'b0, '0, 1'b0);
        chk("hold_full_lit", in_ready, 1'b0);
        do_reset();
        chk("post_reset_lit", output_data, 2'b10);
        chk("post_reset_ready", in_ready, 1'b1);
        repeat (8) tick(1'b0, '0, 1'b0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
